// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEMRD,
    WB,
    BRANCH
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_REG,
    CLS_BR
  } opcls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef struct packed {
    logic       memreq;
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       immsrc;
    logic       alusrc;
    logic [2:0] aluctrl;
    logic       regwrite;
    logic       resultsrc;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// ALU operation decode from op class, funct3 and instr[30].
module alu_decoder
  import mc_pkg::*;
(
  input  opcls_t     cls,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [2:0] aluctrl,
  output logic       illegal
);

  always_comb begin
    aluctrl = ALU_ADD;
    illegal = 1'b0;
    unique case (cls)
      CLS_REG: begin
        unique case (funct3)
          3'b000:  aluctrl = bit30 ? ALU_SUB : ALU_ADD;
          3'b111:  aluctrl = ALU_AND;
          3'b110:  aluctrl = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      CLS_BR: begin
        aluctrl = ALU_SUB;
        illegal = (funct3[2:1] != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32 control FSM (lw/addi/R-type/beq/bne).
// Define RETIRE_CNT_EN to add the RetireCnt retired-instruction counter.
module mc_control
  import mc_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   MemReq,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   PCSrc,
  output logic                   ImmSrc,
  output logic                   ALUSrc,
  output logic [2:0]             ALUctrl,
  output logic                   RegWrite,
  output logic                   ResultSrc,
  output logic                   Illegal
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   RetireCnt
`endif
);

  state_t     state;
  state_t     state_nxt;
  opcls_t     cls;
  ctl_t       ctl;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       known;
  logic [2:0] dec_ctrl;
  logic       dec_ill;
  logic       unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign known  = opcode inside {OP_LOAD, OP_IMM, OP_REG, OP_BRANCH};
  assign unused_instr =
    ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

  always_comb begin
    cls = CLS_ADD;
    unique case (1'b1)
      (opcode == OP_REG):    cls = CLS_REG;
      (opcode == OP_BRANCH): cls = CLS_BR;
      default: ;
    endcase
  end

  alu_decoder u_dec (
    .cls     (cls),
    .funct3  (funct3),
    .bit30   (instr[30]),
    .aluctrl (dec_ctrl),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:  if (MemReady) state_nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          !known:              state_nxt = FETCH;
          (opcode == OP_BRANCH): state_nxt = BRANCH;
          default:             state_nxt = EXEC;
        endcase
      end
      EXEC: begin
        unique case (1'b1)
          dec_ill:             state_nxt = FETCH;
          (opcode == OP_LOAD): state_nxt = MEMRD;
          default:             state_nxt = WB;
        endcase
      end
      MEMRD:  if (MemReady) state_nxt = WB;
      WB:     state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // An R-type with an unsupported funct3 is skipped like a bad opcode
  always_comb begin
    ctl = '0;
    unique case (state)
      FETCH: begin
        ctl.memreq  = 1'b1;
        ctl.irwrite = MemReady;
      end
      DECODE: begin
        ctl.illegal = !known;
        ctl.pcwrite = !known;
      end
      EXEC: begin
        ctl.alusrc  = (cls != CLS_REG);
        ctl.aluctrl = dec_ctrl;
        ctl.illegal = dec_ill;
        ctl.pcwrite = dec_ill;
      end
      MEMRD: ctl.memreq = 1'b1;
      WB: begin
        ctl.regwrite  = 1'b1;
        ctl.resultsrc = (opcode == OP_LOAD);
        ctl.pcwrite   = 1'b1;
      end
      BRANCH: begin
        ctl.immsrc  = 1'b1;
        ctl.aluctrl = dec_ctrl;
        ctl.pcwrite = 1'b1;
        ctl.illegal = dec_ill;
        ctl.pcsrc   = !dec_ill && (Zero ^ funct3[0]);
      end
      default: ;
    endcase
  end

  assign {MemReq, IRWrite, PCWrite, PCSrc, ImmSrc, ALUSrc,
          ALUctrl, RegWrite, ResultSrc, Illegal} = rst ? '0 : ctl;

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      RetireCnt <= '0;
    else if (PCWrite && !Illegal)
      RetireCnt <= RetireCnt + CNT_WIDTH'(1);
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against a per-cycle plan model.
module tb_mc_control;

  localparam int CW   = 4;
  localparam int CMOD = 1 << CW;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_IMM = 7'b0010011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_BR  = 7'b1100011;

  typedef struct packed {
    logic       memreq;
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       immsrc;
    logic       alusrc;
    logic [2:0] aluctrl;
    logic       regwrite;
    logic       resultsrc;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic rdy;
    logic z;
    exp_t e;
  } cyc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr = '0;
  logic          Zero = 1'b0;
  logic          MemReady = 1'b0;
  logic          MemReq, IRWrite, PCWrite, PCSrc, ImmSrc, ALUSrc;
  logic [2:0]    ALUctrl;
  logic          RegWrite, ResultSrc, Illegal;
`ifdef RETIRE_CNT_EN
  logic [CW-1:0] RetireCnt;
`endif

  cyc_t plan[$];
  int   checks = 0;
  int   errors = 0;
  int   rc = 0;

  mc_control #(.INSTR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .ImmSrc    (ImmSrc),
    .ALUSrc    (ALUSrc),
    .ALUctrl   (ALUctrl),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .Illegal   (Illegal)
`ifdef RETIRE_CNT_EN
    ,
    .RetireCnt (RetireCnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_vec();
    dut_vec = {MemReq, IRWrite, PCWrite, PCSrc, ImmSrc, ALUSrc,
               ALUctrl, RegWrite, ResultSrc, Illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cnt();
`ifdef RETIRE_CNT_EN
    chk("retire_cnt", 32'(RetireCnt), 32'(rc));
`endif
  endtask

  function automatic logic rb(input int zf);
    rb = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
  endfunction

  function automatic void push(input exp_t e, input logic r, input logic z);
    cyc_t c;
    c.rdy = r;
    c.z   = z;
    c.e   = e;
    plan.push_back(c);
  endfunction

  // {illegal, aluctrl} for an R-type instruction
  function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic b30);
    case (f3)
      3'b000:  r_alu = {1'b0, 2'b00, b30};
      3'b111:  r_alu = 4'b0010;
      3'b110:  r_alu = 4'b0011;
      default: r_alu = 4'b1000;
    endcase
  endfunction

  // Expected cycle-by-cycle outputs for one instruction
  function automatic void build(input logic [31:0] ins, input int fw,
                                input int mw, input int zf);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [3:0] ra;
    logic       z;
    exp_t       e;
    opc = ins[6:0];
    f3  = ins[14:12];
    plan.delete();
    for (int k = 0; k < fw; k++) begin
      e = '0; e.memreq = 1'b1; push(e, 1'b0, rb(zf));
    end
    e = '0; e.memreq = 1'b1; e.irwrite = 1'b1; push(e, 1'b1, rb(zf));
    e = '0;
    if (!(opc inside {T_LW, T_IMM, T_R, T_BR})) begin
      e.illegal = 1'b1; e.pcwrite = 1'b1;
      push(e, rb(-1), rb(zf));
      return;
    end
    push(e, rb(-1), rb(zf));
    if (opc == T_BR) begin
      z = rb(zf);
      e = '0; e.immsrc = 1'b1; e.aluctrl = 3'b001; e.pcwrite = 1'b1;
      if (f3 == 3'b000) e.pcsrc = z;
      else if (f3 == 3'b001) e.pcsrc = ~z;
      else e.illegal = 1'b1;
      push(e, rb(-1), z);
      return;
    end
    ra = (opc == T_R) ? r_alu(f3, ins[30]) : 4'b0000;
    e = '0; e.alusrc = (opc != T_R); e.aluctrl = ra[2:0];
    if (ra[3]) begin
      e.illegal = 1'b1; e.pcwrite = 1'b1;
      push(e, rb(-1), rb(zf));
      return;
    end
    push(e, rb(-1), rb(zf));
    if (opc == T_LW) begin
      for (int k = 0; k < mw; k++) begin
        e = '0; e.memreq = 1'b1; push(e, 1'b0, rb(zf));
      end
      e = '0; e.memreq = 1'b1; push(e, 1'b1, rb(zf));
    end
    e = '0; e.regwrite = 1'b1; e.resultsrc = (opc == T_LW); e.pcwrite = 1'b1;
    push(e, rb(-1), rb(zf));
  endfunction

  task automatic hit_reset();
    exp_t e;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(dut_vec()), 32'd0);
    rc = 0;
    @(posedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    Zero = 1'b0;
    rst = 1'b0;
    #2;
    e = '0; e.memreq = 1'b1;
    chk("rst_release", 32'(dut_vec()), 32'(e));
    chk_cnt();
  endtask

  task automatic run(input logic [31:0] ins, input int fw, input int mw,
                     input int zf, input int stop,
                     output int lat, output int nreq);
    int s;
    build(ins, fw, mw, zf);
    s = (stop == -2) ? int'($urandom_range(0, plan.size() - 1)) : stop;
    lat = -1;
    nreq = 0;
    foreach (plan[i]) begin
      @(negedge clk);
      MemReady = plan[i].rdy;
      Zero = plan[i].z;
      #2;
      chk("ctl", 32'(dut_vec()), 32'(plan[i].e));
      chk_cnt();
      if (PCWrite && lat < 0) lat = i + 1;
      if (MemReq) nreq++;
      if (i == s) begin
        hit_reset();
        break;
      end
      if (plan[i].e.pcwrite && !plan[i].e.illegal) rc = (rc + 1) % CMOD;
      @(posedge clk);
      #1;
      if (plan[i].e.irwrite) instr = ins;
    end
  endtask

  initial begin
    int lat;
    int nr;
    logic [31:0] ins;
    #2;
    chk("rst_outputs", 32'(dut_vec()), 32'd0);
    hit_reset();

    run(32'h00500093, 0, 0, -1, -1, lat, nr);
    chk("addi_lat", 32'(lat), 32'd4);
    chk("addi_irw_c1", 32'(plan[0].e.irwrite), 32'd1);
    chk("addi_exec_alusrc", 32'(plan[2].e.alusrc), 32'd1);
    chk("addi_wb_regwr", 32'(plan[3].e.regwrite), 32'd1);
    run(32'h00a00113, 0, 0, -1, -1, lat, nr);
    run(32'h00100193, 1, 0, -1, -1, lat, nr);
    chk("addi_fw1_lat", 32'(lat), 32'd5);
    run(32'h0020a023, 0, 0, -1, -1, lat, nr);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_illegal", 32'(plan[1].e.illegal), 32'd1);
`ifdef RETIRE_CNT_EN
    chk("retire_3", 32'(RetireCnt), 32'd3);
`endif
    run(32'h0000a203, 0, 3, -1, -1, lat, nr);
    chk("lw_lat", 32'(lat), 32'd8);
    chk("lw_memreq_cycles", 32'(nr), 32'd5);
    run(32'h00000463, 0, 0, 1, -1, lat, nr);
    chk("beq_lat", 32'(lat), 32'd3);
    chk("beq_pcsrc", 32'(plan[2].e.pcsrc), 32'd1);
    run(32'h00001463, 0, 0, 1, -1, lat, nr);
    chk("bne_pcsrc", 32'(plan[2].e.pcsrc), 32'd0);
    run(32'h00500093, 0, 0, -1, 3, lat, nr);
    run(32'h0000a203, 0, 3, -1, 4, lat, nr);

    for (int k = 0; k < CMOD - 1; k++) run(32'h00500093, 0, 0, -1, -1, lat, nr);
`ifdef RETIRE_CNT_EN
    chk("retire_allones", 32'(RetireCnt), 32'(CMOD - 1));
`endif
    run(32'h00500093, 0, 0, -1, -1, lat, nr);
`ifdef RETIRE_CNT_EN
    chk("retire_wrap", 32'(RetireCnt), 32'd0);
`endif

    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 8: ins[6:0] = T_IMM;
        2, 9:    ins[6:0] = T_LW;
        3, 4: begin
          ins[6:0] = T_R;
          case ($urandom_range(0, 4))
            0, 3: ins[14:12] = 3'b000;
            1:    ins[14:12] = 3'b111;
            2:    ins[14:12] = 3'b110;
            default: ;
          endcase
        end
        5, 6: begin
          ins[6:0] = T_BR;
          if ($urandom_range(0, 3) != 3) ins[14:12] = {2'b00, ins[12]};
        end
        default: begin
          if (ins[6:0] inside {T_LW, T_IMM, T_R, T_BR})
            ins[6:0] = ins[6:0] ^ 7'b0000100;
        end
      endcase
      run(ins, $urandom_range(0, 2), $urandom_range(0, 3), -1,
          ($urandom_range(0, 24) == 0) ? -2 : -1, lat, nr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The module SHALL have parameter INSTR_WIDTH, default 32, meaning instruction register width.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 32, meaning retired-instruction counter width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all flops update on the rising edge.
REQ-004 The module SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 The module SHALL have port instr, input, INSTR_WIDTH, the current instruction-register contents.
REQ-006 The module SHALL have port Zero, input, 1, the ALU zero flag.
REQ-007 The module SHALL have port MemReady, input, 1, memory completion for the current MemReq.
REQ-008 The module SHALL have port MemReq, output, 1, the memory access request (fetch or load).
REQ-009 The module SHALL have port IRWrite, output, 1, the instruction-register load strobe.
REQ-010 The module SHALL have port PCWrite, output, 1, the PC update strobe.
REQ-011 The module SHALL have port PCSrc, output, 1: 0 selects PC+4, 1 selects PC+ImmOp.
REQ-012 The module SHALL have port ImmSrc, output, 1, driving the sign-extend unit: 0 = I-type, 1 = B-type.
REQ-013 The module SHALL have ports ALUSrc, output, 1 (1 = ImmOp operand), and ALUctrl, output, 3, the ALU operation.
REQ-014 The module SHALL have ports RegWrite, output, 1, and ResultSrc, output, 1 (1 = memory data).
REQ-015 The module SHALL have port Illegal, output, 1, a one-cycle pulse for an unsupported opcode.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, MEMRD, WB, BRANCH; the reset state is FETCH.
REQ-017 FETCH SHALL assert MemReq and hold it until MemReady; on the MemReady cycle it SHALL assert IRWrite and go to DECODE.
REQ-018 DECODE SHALL use opcode instr[6:0]: 0000011 (lw), 0010011 (addi) or 0110011 (R-type) go to EXEC; 1100011 (beq/bne) goes to BRANCH.
REQ-019 DECODE SHALL pulse Illegal for any other opcode, assert PCWrite with PCSrc=0, and return to FETCH.
REQ-020 In EXEC, ALUSrc SHALL be 1 for lw/addi and 0 for R-type, with ImmSrc=0.
REQ-021 EXEC SHALL then go to MEMRD for lw and to WB otherwise.
REQ-022 ALUctrl SHALL be 000 (add) for lw/addi, and 000/001/010/011 for R-type funct3 000 with instr[30]=0 / 000 with instr[30]=1 / 111 / 110; other funct3 values SHALL pulse Illegal.
REQ-023 MEMRD SHALL hold MemReq until MemReady, then go to WB.
REQ-024 WB SHALL assert RegWrite for one cycle, with ResultSrc=1 for lw and 0 otherwise, plus PCWrite with PCSrc=0, then go to FETCH.
REQ-025 BRANCH SHALL drive ImmSrc=1, ALUSrc=0, ALUctrl=001 (sub) and PCWrite=1 for one cycle, then go to FETCH.
REQ-026 In BRANCH, PCSrc SHALL be (funct3==000 ? Zero : ~Zero); funct3 values other than 000 and 001 SHALL pulse Illegal with PCSrc=0.
REQ-027 Outputs SHALL be Moore-decoded from state plus registered instr fields; in every state the FSM does not explicitly drive, strobes SHALL be 0, ImmSrc 0, ALUSrc 0, ALUctrl 000.
REQ-028 Latency SHALL be: ALU ops 4 cycles, branches 3 cycles, lw 5 cycles, each measured with MemReady asserted in the first request cycle; every wait cycle adds one.
REQ-029 MemReady outside FETCH/MEMRD SHALL be ignored; MemReq SHALL never drop while waiting.

Reset
REQ-030 Asserting rst SHALL force state FETCH and all outputs 0 asynchronously, including mid-wait and mid-WB with no RegWrite/PCWrite.
REQ-031 After rst deasserts, MemReq SHALL be asserted in the first clock cycle.

Configuration
REQ-032 With RETIRE_CNT_EN defined, the module SHALL add output RetireCnt[CNT_WIDTH-1:0] that resets to 0, increments on each cycle where PCWrite=1 and Illegal=0, and wraps to 0 from all-ones.
REQ-033 Without RETIRE_CNT_EN, the port and the counter logic SHALL be absent.

Structure
REQ-034 Package mc_pkg SHALL hold the state enum, opcode localparams (OP_LOAD, OP_IMM, OP_REG, OP_BRANCH) and the ALUctrl encodings.
REQ-035 One sub-module, alu_decoder (funct3/instr[30]/op class -> ALUctrl, illegal), SHALL be instantiated.

Verification
REQ-036 addi x1,x0,5 (0x00500093) with MemReady tied high -> IRWrite at cycle 1, EXEC ALUSrc=1 ALUctrl=000, RegWrite in cycle 4, PCSrc=0.
REQ-037 lw with MemReady delayed 3 cycles in MEMRD -> MemReq held 4 cycles, RegWrite with ResultSrc=1, total 8 cycles.
REQ-038 beq with Zero=1 -> ImmSrc=1, PCSrc=1, PCWrite in cycle 3; bne with Zero=1 -> PCSrc=0.
REQ-039 Opcode 0100011 (sw) -> Illegal for one cycle in DECODE, PCWrite with PCSrc=0, next state FETCH.
REQ-040 rst asserted in WB -> RegWrite=0 immediately and FETCH with MemReq=1 on the first cycle after release.
REQ-041 With RETIRE_CNT_EN: 3 addi + 1 illegal -> RetireCnt=3; with the counter preloaded near all-ones, it wraps to 0.
